// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle between the issue stage and module_alu_mdu.
//   slave  : the arithmetic unit (takes the request, drives the result/handshake)
//   master : the issuing stage
// Request : valid_i, flush_i, alu_op_i, opb5_i, funct3_i, funct7b5_i,
//           funct7b0_i, src_a_i, src_b_i
// Response: ready_o, result_o, valid_o, busy_o, illegal_o
interface alu_mdu_if #(parameter int WIDTH = 32);
  logic             valid_i;
  logic             ready_o;
  logic             flush_i;
  logic [1:0]       alu_op_i;
  logic             opb5_i;
  logic [2:0]       funct3_i;
  logic             funct7b5_i;
  logic             funct7b0_i;
  logic [WIDTH-1:0] src_a_i;
  logic [WIDTH-1:0] src_b_i;
  logic [WIDTH-1:0] result_o;
  logic             valid_o;
  logic             busy_o;
  logic             illegal_o;

  modport slave (
    input  valid_i, flush_i, alu_op_i, opb5_i, funct3_i, funct7b5_i, funct7b0_i,
           src_a_i, src_b_i,
    output ready_o, result_o, valid_o, busy_o, illegal_o
  );

  modport master (
    output valid_i, flush_i, alu_op_i, opb5_i, funct3_i, funct7b5_i, funct7b0_i,
           src_a_i, src_b_i,
    input  ready_o, result_o, valid_o, busy_o, illegal_o
  );
endinterface

// File: rtl/module_alu_mdu.sv
// module_alu_mdu: RV32I/RV32M execute-stage arithmetic unit.
//   Base ALU ops and multiply complete one cycle after acceptance with a
//   registered result. div/divu/rem/remu run on an iterative restoring
//   divider (one quotient bit per cycle) that holds ready_o low while busy.
// Ports:
//   clk_i    : clock, all state on rising edge
//   rst_n_i  : asynchronous active-low reset
//   bus      : alu_mdu_if.slave (request fields, handshake, result)
// Build option:
//   ALU_MDU_DIV_EN : when defined the divide FSM is built; otherwise divide
//                    ops return 0 with illegal_o set, one cycle latency.
module module_alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  alu_mdu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] a, b;
  logic [2:0]       f3;
  logic [SW-1:0]    shamt;
  assign a     = bus.src_a_i;
  assign b     = bus.src_b_i;
  assign f3    = bus.funct3_i;
  assign shamt = b[SW-1:0];

  logic is_m, is_div, ready, accept;
  assign is_m   = bus.alu_op_i[1] & bus.opb5_i & bus.funct7b0_i;
  assign is_div = is_m & f3[2];
  assign accept = bus.valid_i & ready & ~bus.flush_i;

  // ---------------- base ALU ----------------
  logic [WIDTH-1:0] base_res;
  always_comb begin
    base_res = '0;
    unique case (f3)
      3'b000: base_res = (bus.opb5_i & bus.funct7b5_i) ? a - b : a + b;
      3'b001: base_res = a << shamt;
      3'b010: base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011: base_res = {{(WIDTH-1){1'b0}}, (a < b)};
      3'b100: base_res = a ^ b;
      3'b101: base_res = bus.funct7b5_i ? WIDTH'($signed(a) >>> shamt) : a >> shamt;
      3'b110: base_res = a | b;
      default: base_res = a & b;
    endcase
  end

  // ---------------- multiply ----------------
  // Operands are extended to 2*WIDTH according to funct3 signedness; the
  // product modulo 2^(2*WIDTH) is then the exact two's-complement product.
  logic                 a_sx, b_sx;
  logic [2*WIDTH-1:0]   pa, pb, prod;
  logic [WIDTH-1:0]     mul_res;
  always_comb begin
    a_sx    = (f3[1:0] == 2'b01) | (f3[1:0] == 2'b10);
    b_sx    = (f3[1:0] == 2'b01);
    pa      = {{WIDTH{a_sx & a[WIDTH-1]}}, a};
    pb      = {{WIDTH{b_sx & b[WIDTH-1]}}, b};
    prod    = pa * pb;
    mul_res = (f3[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  // ---------------- single-cycle result ----------------
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;
  logic             div_start;
  logic             done_vld;
  logic [WIDTH-1:0] div_res;

`ifdef ALU_MDU_DIV_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
  state_t state, state_nxt;

  logic             signed_op, a_neg, b_neg, b_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res;
  always_comb begin
    signed_op = ~f3[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    b_zero    = (b == '0);
    ovf       = signed_op & (a == MIN_NEG) & (b == '1);
    // div-by-zero and signed overflow bypass the FSM entirely
    if (b_zero) spec_res = f3[1] ? a : '1;
    else        spec_res = f3[1] ? '0 : MIN_NEG;
  end
  assign div_start = accept & is_div & ~b_zero & ~ovf;

  logic [WIDTH-1:0] quo, rem, dvs;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, is_rem;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (bus.flush_i) state_nxt = S_IDLE;
    else begin
      unique case (state)
        S_IDLE: if (div_start) state_nxt = S_DIV;
        S_DIV:  if (cnt == CW'(1)) state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    ready    = (state == S_IDLE);
    done_vld = (state == S_DONE) & ~bus.flush_i;
  end

  // Restoring step: shift next dividend bit into the partial remainder and
  // subtract the divisor if it fits (top bit of diff is the borrow).
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
    end else if (div_start) begin
      quo    <= a_mag;
      rem    <= '0;
      dvs    <= b_mag;
      cnt    <= CW'(WIDTH);
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      is_rem <= f3[1];
    end else if (state == S_DIV) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    if (is_rem) div_res = neg_r ? -rem : rem;
    else        div_res = neg_q ? -quo : quo;
  end

  assign bus.busy_o = (state != S_IDLE);
  assign sc_ill     = 1'b0;
`else
  assign ready      = 1'b1;
  assign div_start  = 1'b0;
  assign done_vld   = 1'b0;
  assign div_res    = '0;
  assign bus.busy_o = 1'b0;
  assign sc_ill     = is_div;
`endif

  always_comb begin
    unique case (bus.alu_op_i)
      2'b00:   sc_res = a + b;
      2'b01:   sc_res = a - b;
      default: sc_res = base_res;
    endcase
    if (is_m) sc_res = mul_res;
`ifdef ALU_MDU_DIV_EN
    if (is_div) sc_res = spec_res;
`else
    if (is_div) sc_res = '0;
`endif
  end

  // ---------------- output registers ----------------
  logic [WIDTH-1:0] result_r;
  logic             valid_r, illegal_r;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_r  <= '0;
      valid_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      valid_r   <= 1'b0;
      illegal_r <= 1'b0;
      if (accept && !div_start) begin
        result_r  <= sc_res;
        valid_r   <= 1'b1;
        illegal_r <= sc_ill;
      end else if (done_vld) begin
        // keep the divide result visible after the DONE pulse
        result_r <= div_res;
      end
    end
  end

  // During DONE the divider result is presented directly so that a flush in
  // that same cycle can suppress both the pulse and the new value.
  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_r | done_vld;
  assign bus.result_o  = done_vld ? div_res : result_r;
  assign bus.illegal_o = illegal_r;
endmodule

// File: tb/tb_module_alu_mdu.sv
module tb_module_alu_mdu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(32)) bus();
  module_alu_mdu #(.WIDTH(32)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic vld, input logic [1:0] op, input logic opb5, input logic f7b5,
                        input logic f7b0, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i    = vld;
    bus.alu_op_i   = op;
    bus.opb5_i     = opb5;
    bus.funct7b5_i = f7b5;
    bus.funct7b0_i = f7b0;
    bus.funct3_i   = f3;
    bus.src_a_i    = a;
    bus.src_b_i    = b;
  endtask

  // Reference model: RISC-V semantics from plain integer arithmetic.
  task automatic model(input logic [1:0] op, input logic opb5, input logic f7b5, input logic f7b0,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    ill = 1'b0;
    lat = 1;
    r = '0;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (opb5 && f7b0) begin
      case (f3)
        3'd0: r = a * b;
        3'd1: begin p = 64'(longint'(sa) * longint'(sb)); r = p[63:32]; end
        3'd2: begin p = 64'(longint'(sa) * longint'({32'h0, b})); r = p[63:32]; end
        3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
        default: begin
`ifdef ALU_MDU_DIV_EN
          if (b == 0) r = f3[1] ? a : 32'hFFFF_FFFF;
          else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = f3[1] ? 32'h0 : 32'h8000_0000;
          else begin
            lat = 33;
            case (f3[1:0])
              2'd0: r = 32'(sa / sb);
              2'd1: r = a / b;
              2'd2: r = 32'(sa % sb);
              default: r = a % b;
            endcase
          end
`else
          r = '0;
          ill = 1'b1;
`endif
        end
      endcase
    end else begin
      case (f3)
        3'd0: r = (opb5 && f7b5) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = f7b5 ? 32'(sa >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
  endtask

  // Issue one op, wait (bounded) for valid_o, check result, latency, handshake.
  task automatic run_op(input string tag, input logic [1:0] op, input logic opb5, input logic f7b5,
                        input logic f7b0, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic eill;
    int elat, n, rdy_hi, bsy;
    model(op, opb5, f7b5, f7b0, f3, a, b, er, eill, elat);
    @(negedge clk);
    chk({tag, " rdy"}, 64'(bus.ready_o), 64'd1);
    set_in(1'b1, op, opb5, f7b5, f7b0, f3, a, b);
    @(negedge clk);
    bus.valid_i = 1'b0;
    n = 1; rdy_hi = 0; bsy = 0;
    forever begin
      if (bus.ready_o) rdy_hi++;
      if (bus.busy_o) bsy++;
      if (bus.valid_o || n >= 60) break;
      @(negedge clk);
      n++;
    end
    chk({tag, " lat"}, 64'(n), 64'(elat));
    chk({tag, " res"}, 64'(bus.result_o), 64'(er));
    chk({tag, " ill"}, 64'(bus.illegal_o), 64'(eill));
    chk({tag, " rdylow"}, 64'(rdy_hi), (elat > 1) ? 64'd0 : 64'd1);
    chk({tag, " busy"}, 64'(bsy), (elat > 1) ? 64'(elat) : 64'd0);
    @(negedge clk);
    chk({tag, " pulse"}, 64'(bus.valid_o), 64'd0);
    chk({tag, " hold"}, 64'(bus.result_o), 64'(er));
  endtask

  initial begin
    logic [31:0] er, a, b;
    logic eill, have;
    logic [1:0] op;
    logic [2:0] f3;
    logic opb5, f7b5, f7b0;
    int elat, n, cnt;

    bus.flush_i = 1'b0;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #12;
    chk("rst result", 64'(bus.result_o), 64'd0);
    chk("rst valid", 64'(bus.valid_o), 64'd0);
    chk("rst ready", 64'(bus.ready_o), 64'd1);
    chk("rst busy", 64'(bus.busy_o), 64'd0);
    chk("rst ill", 64'(bus.illegal_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vectors
    run_op("sub", 2'b01, 1'b1, 1'b1, 1'b0, 3'd0, 32'd5, 32'd7);
    run_op("sra", 2'b10, 1'b1, 1'b1, 1'b0, 3'd5, 32'h8000_0000, 32'd4);
    run_op("srai", 2'b10, 1'b0, 1'b1, 1'b0, 3'd5, 32'h8000_0000, 32'd4);
    run_op("sltu", 2'b10, 1'b1, 1'b0, 1'b0, 3'd3, 32'd1, 32'hFFFF_FFFF);
    run_op("slt", 2'b10, 1'b1, 1'b0, 1'b0, 3'd2, 32'd1, 32'hFFFF_FFFF);
    run_op("mulh", 2'b10, 1'b1, 1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu", 2'b10, 1'b1, 1'b0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu", 2'b10, 1'b1, 1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul", 2'b10, 1'b1, 1'b0, 1'b1, 3'd0, 32'd3, 32'hFFFF_FFFC);
    run_op("div", 2'b10, 1'b1, 1'b0, 1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem", 2'b10, 1'b1, 1'b0, 1'b1, 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", 2'b10, 1'b1, 1'b0, 1'b1, 3'd5, 32'd10, 32'd3);
    run_op("div0", 2'b10, 1'b1, 1'b0, 1'b1, 3'd4, 32'h1234_5678, 32'd0);
    run_op("rem0", 2'b10, 1'b1, 1'b0, 1'b1, 3'd6, 32'h1234_5678, 32'd0);
    run_op("divovf", 2'b10, 1'b1, 1'b0, 1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("removf", 2'b10, 1'b1, 1'b0, 1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // back-to-back random non-divide ops, one accept per cycle
    have = 1'b0;
    er = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (have) begin
        chk("b2b vld", 64'(bus.valid_o), 64'd1);
        chk("b2b res", 64'(bus.result_o), 64'(er));
      end
      op = 2'($urandom); opb5 = 1'($urandom); f7b5 = 1'($urandom); f7b0 = 1'($urandom);
      f3 = 3'($urandom); a = $urandom; b = $urandom;
      if (op[1] && opb5 && f7b0 && f3[2]) f7b0 = 1'b0;
      set_in(1'b1, op, opb5, f7b5, f7b0, f3, a, b);
      model(op, opb5, f7b5, f7b0, f3, a, b, er, eill, elat);
      have = 1'b1;
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("b2b last", 64'(bus.result_o), 64'(er));

    // random divides, including zero, small and overflow divisors
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 17));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) b = -b;
      run_op("rdiv", 2'b10, 1'b1, 1'b0, 1'b1, 3'(4 + $urandom_range(0, 3)), a, b);
    end

    // flush drops a same-cycle request
    @(negedge clk);
    bus.flush_i = 1'b1;
    set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 32'd40, 32'd2);
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    chk("flush drop", 64'(bus.valid_o), 64'd0);

`ifdef ALU_MDU_DIV_EN
    // flush at cycle 10 of a divide
    @(negedge clk);
    set_in(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    bus.valid_i = 1'b0;
    n = 1; cnt = 0;
    while (n < 10) begin
      if (bus.valid_o) cnt++;
      @(negedge clk);
      n++;
    end
    bus.flush_i = 1'b1;
    set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 32'd40, 32'd2);
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    chk("fl vld", 64'(bus.valid_o), 64'd0);
    chk("fl rdy", 64'(bus.ready_o), 64'd1);
    chk("fl busy", 64'(bus.busy_o), 64'd0);
    set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 32'd11, 32'd31);
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("fl add vld", 64'(bus.valid_o), 64'd1);
    chk("fl add res", 64'(bus.result_o), 64'd42);
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) cnt++;
    end
    chk("fl stray", 64'(cnt), 64'd0);
`endif

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1, 32'd2);
    @(negedge clk);
    set_in(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 3'd5, 32'd100, 32'd7);
    @(negedge clk);
    bus.valid_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst result", 64'(bus.result_o), 64'd0);
    chk("arst valid", 64'(bus.valid_o), 64'd0);
    chk("arst ready", 64'(bus.ready_o), 64'd1);
    chk("arst busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post rst", 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 32'd20, 32'd22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
